i2sout: RTL

I2S transmitter: the upstream stage that produces the serial `ws`/`sd` stream consumed by the I2S receiver. It accepts stereo sample pairs from the mixer core over a valid/ready handshake and buffers one pair in a holding register. It serializes each sample MSB-first into fixed-width slots, applying the standard I2S one-bit data delay. When no sample pair is available at a frame boundary, it sends zeros and flags the underrun.

---
 rtl/i2s_pkg.sv | 13 +
 rtl/i2sout_shifter.sv | 43 ++++
 rtl/i2sout.sv | 131 +++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// ----------------------------------------------------------------------------
// i2s_pkg
//   Constants shared by the I2S transmitter and receiver.
//
//   WS_LEFT  : word-select level during the left channel slot
//   WS_RIGHT : word-select level during the right channel slot
// ----------------------------------------------------------------------------
package i2s_pkg;

  localparam logic WS_LEFT  = 1'b1;
  localparam logic WS_RIGHT = 1'b0;

endpackage

// File: rtl/i2sout_shifter.sv
// ----------------------------------------------------------------------------
// i2sout_shifter
//   Frame shift register for the I2S transmitter. A whole frame (left slot
//   word followed by right slot word) is loaded in parallel at the frame
//   start and shifted out MSB-first, one bit per sck falling edge. The output
//   flop adds the one-bit I2S data delay relative to the frame boundary.
//
//   Ports
//     sck        in   bit clock, all state changes on the falling edge
//     rst        in   synchronous, active-high reset
//     load       in   parallel load strobe (frame start)
//     load_word  in   [FRAME_BITS-1:0] frame contents, left slot in the MSBs
//     sd         out  delayed serial data
// ----------------------------------------------------------------------------
module i2sout_shifter #(
  parameter int FRAME_BITS = 8
) (
  input  logic                  sck,
  input  logic                  rst,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] load_word,
  output logic                  sd
);

  logic [FRAME_BITS-1:0] shreg;

  always_ff @(negedge sck) begin
    if (rst) begin
      shreg <= '0;
      sd    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignment means sd takes the MSB held before this
      // edge's load/shift, which is exactly the one-bit I2S delay.
      sd <= shreg[FRAME_BITS-1];
      if (load) begin
        shreg <= load_word;
      end else begin
        shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/i2sout.sv
// ----------------------------------------------------------------------------
// i2sout
//   I2S transmitter. Accepts stereo sample pairs over a valid/ready handshake
//   into a single holding register, and at every frame start moves the held
//   pair into the frame shifter. Each channel occupies SLOT_BITS sck periods:
//   the sample MSB-first followed by zero padding. When the holding register
//   is empty at a frame start the frame carries zeros and underrun pulses
//   (except for the very first frame after reset).
//
//   Parameters
//     BITS_PRECISION  sample width
//     SLOT_BITS       sck periods per channel slot
//                     (SLOT_BITS >= BITS_PRECISION, SLOT_BITS >= 2)
//
//   Ports
//     sck         in   bit clock, all registers update on the falling edge
//     rst         in   synchronous, active-high reset
//     data_left   in   [BITS_PRECISION-1:0] left sample
//     data_right  in   [BITS_PRECISION-1:0] right sample
//     data_valid  in   sample pair present
//     data_ready  out  holding register empty (registered)
//     ws          out  word select, 1 = left slot, 0 = right slot
//     sd          out  serial data
//     underrun    out  one-cycle pulse, frame started with nothing to send
// ----------------------------------------------------------------------------
module i2sout
  import i2s_pkg::*;
#(
  parameter int BITS_PRECISION = 4,
  parameter int SLOT_BITS      = 4
) (
  input  logic                      sck,
  input  logic                      rst,
  input  logic [BITS_PRECISION-1:0] data_left,
  input  logic [BITS_PRECISION-1:0] data_right,
  input  logic                      data_valid,
  output logic                      data_ready,
  output logic                      ws,
  output logic                      sd,
  output logic                      underrun
);

  localparam int MSB        = BITS_PRECISION - 1;
  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  // Last position in the frame, and the first position of the right slot.
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_RIGHT = CNT_W'(SLOT_BITS);

  // cnt holds the frame position of the upcoming edge; 0 marks a frame start.
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic [MSB:0]          hold_left;
  logic [MSB:0]          hold_right;
  logic                  hold_full;
  logic                  hold_full_next;
  logic                  first_frame;
  logic                  frame_start;
  logic                  accept;
  logic [FRAME_BITS-1:0] load_word;

  // Sample left-justified in its slot, padding bits zero.
  function automatic logic [SLOT_BITS-1:0] slot_word(input logic [MSB:0] sample);
    logic [SLOT_BITS-1:0] w;
    w = '0;
    w[SLOT_BITS-1 -: BITS_PRECISION] = sample;
    return w;
  endfunction

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it holding its old value and infer a latch.
    cnt_next       = cnt + 1'b1;
    frame_start    = (cnt == '0);
    accept         = data_valid && data_ready;
    load_word      = '0;

    if (cnt == CNT_LAST) begin
      cnt_next = '0;
    end

    // The frame load empties the register; an accept (only possible while
    // empty) fills it. A pair accepted at a frame start is held for the next
    // frame, never bypassed into the current one.
    hold_full_next = (hold_full && !frame_start) || accept;

    if (frame_start && hold_full) begin
      load_word = {slot_word(hold_left), slot_word(hold_right)};
    end
  end

  always_ff @(negedge sck) begin
    if (rst) begin
      cnt         <= '0;
      hold_full   <= 1'b0;
      // NOTE: the holding pair is two plain registers, not a memory array, so
      // clearing it in reset is cheap and keeps discarded data from lingering.
      hold_left   <= '0;
      hold_right  <= '0;
      first_frame <= 1'b1;
      ws          <= WS_RIGHT;
      data_ready  <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      hold_full   <= hold_full_next;
      first_frame <= 1'b0;
      if (accept) begin
        hold_left  <= data_left;
        hold_right <= data_right;
      end
      // ws leads the slot's MSB on sd by one sck because of the data delay.
      ws          <= (cnt < CNT_RIGHT) ? WS_LEFT : WS_RIGHT;
      data_ready  <= !hold_full_next;
      underrun    <= frame_start && !hold_full && !first_frame;
    end
  end

  // The shifter loads at every frame start: the held pair, or zeros on underrun.
  i2sout_shifter #(
    .FRAME_BITS(FRAME_BITS)
  ) u_shifter (
    .sck       (sck),
    .rst       (rst),
    .load      (frame_start),
    .load_word (load_word),
    .sd        (sd)
  );

endmodule
